pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter RESET_VAL, default 0: payload value after reset or flush, for example INST_NOP for instruction lanes.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have these ports:
- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  pipeline clear; kills held and incoming data.
- in_valid_i  input  1  upstream data valid.
- in_ready_o  output  1  stage can accept data.
- in_data_i  input  WIDTH  upstream payload.
- out_valid_o  output  1  downstream data valid.
- out_ready_i  input  1  downstream accepts data.
- out_data_o  output  WIDTH  downstream payload.
- stall_cnt_o  output  CNT_W  back-pressure cycle count; present only with the macro in REQ-020.

Function
REQ-005 SHALL implement a 2-entry skid buffer: a main register drives out_data_o, and a skid register catches data while downstream stalls.
REQ-006 SHALL use three states: EMPTY (no valid entry), FULL (main valid), SKID (main and skid valid).
REQ-007 SHALL define a transfer as valid and ready high in the same cycle on either side.
REQ-008 SHALL drive out_valid_o=1 in FULL and SKID, and in_ready_o=1 in EMPTY and FULL.
REQ-009 SHALL drive in_ready_o from registered state only, with no combinational path from out_ready_i to in_ready_o.
REQ-010 EMPTY transitions SHALL be:
- in_valid_i: load main, go to FULL.
- otherwise: hold EMPTY.
REQ-011 FULL transitions SHALL be:
- in_valid_i and out_ready_i: load main with new data, stay FULL.
- out_ready_i only: go to EMPTY.
- in_valid_i only: load skid, go to SKID.
- neither: hold FULL.
REQ-012 SKID transitions SHALL be:
- out_ready_i: main takes skid, go to FULL.
- otherwise: hold SKID.
- in_data_i is ignored while in SKID.
REQ-013 SHALL have a latency of 1 cycle from an input transfer to out_valid_o high when the stage was EMPTY or the main entry is draining.
REQ-014 SHALL sustain 1 transfer per cycle while out_ready_i stays high.
REQ-015 SHALL keep out_data_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-016 SHALL preserve order: data leaves in acceptance order, with no loss and no duplication.
REQ-017 SHALL give flush_i priority over all handshakes, so that on the next edge:
- state is EMPTY;
- both data registers hold RESET_VAL;
- any input presented in the flush cycle is dropped.
REQ-018 SHALL keep out_data_o at its last value after a normal drain to EMPTY; only reset or flush forces RESET_VAL.

Reset
REQ-019 SHALL, on a clock edge with rst_i=1, set:
- state to EMPTY;
- out_valid_o=0 and in_ready_o=1;
- out_data_o and the skid register to RESET_VAL;
- stall_cnt_o to 0.
rst_i SHALL override flush_i and all handshakes, including mid-transfer and in SKID.

Configuration
REQ-020 With PIPE_SKID_STALL_CNT_EN defined, the block SHALL behave as follows:
- stall_cnt_o exists;
- it increments by 1 on each cycle with out_valid_o=1 and out_ready_i=0;
- it saturates at all-ones;
- it is cleared only by reset, not by flush.
REQ-021 Without PIPE_SKID_STALL_CNT_EN, stall_cnt_o and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 SHALL place the state typedef (EMPTY, FULL, SKID) and a default stall-counter width constant in tinyriscv_pkg.
REQ-023 SHALL place both data registers in one sub-module, pipe_skid_data, which holds WIDTH bits each and takes load-main, load-skid, main-from-skid and clear controls.
REQ-024 SHALL keep the FSM, handshake logic and counter in pipe_skid_stage.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single beat: reset, then in 0xA5A5A5A5 with out_ready_i=1 -> out_valid_o=1 with that data one cycle later; EMPTY the cycle after.
- Streaming: 8 back-to-back beats 1..8 with out_ready_i=1 -> 8 outputs 1..8 on consecutive cycles; in_ready_o constantly 1.
- Stall: beats 0x11 and 0x22 with out_ready_i=0 -> SKID, in_ready_o=0 and out_data_o=0x11 held; after out_ready_i=1, 0x11 then 0x22 drain in order.
- Flush in SKID: flush_i=1 with in_valid_i=1 (0x33) -> next cycle out_valid_o=0 and out_data_o=RESET_VAL; 0x33 never appears.
- Reset mid-stream: rst_i=1 while FULL and in_valid_i=1 -> EMPTY, in_ready_o=1, out_data_o=RESET_VAL, stall_cnt_o=0.
- Counter (macro on, CNT_W=4): hold out_valid_o=1 and out_ready_i=0 for 20 cycles -> stall_cnt_o=15, saturated; a later flush leaves it at 15.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the pipeline skid stage.
//   skid_state_e   : occupancy state of the 2-entry skid buffer
//   SKID_CNT_W_DEF : default width of the optional back-pressure counter
package tinyriscv_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no valid entry
    ST_FULL  = 2'd1,  // main register valid
    ST_SKID  = 2'd2   // main and skid registers valid
  } skid_state_e;

  localparam int SKID_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_skid_data.sv
// Data storage for the skid stage: a main register that drives the
// downstream payload and a skid register that catches one extra beat.
// Ports:
//   clk_i, rst_i      clock / synchronous active-high reset
//   clear_i           flush: both registers return to RESET_VAL
//   load_main_i       main <= data_i
//   load_skid_i       skid <= data_i
//   main_from_skid_i  main <= skid
//   data_i            incoming payload
//   main_o            main register contents
module pipe_skid_data
  import tinyriscv_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_main_i,
  input  logic             load_skid_i,
  input  logic             main_from_skid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] main_o
);

  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  // Reset and flush win over every load so nothing from the clear cycle survives.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_main <= RESET_VAL;
      r_skid <= RESET_VAL;
    end else begin
      if (main_from_skid_i) begin
        r_main <= r_skid;
      end else if (load_main_i) begin
        r_main <= data_i;
      end
      if (load_skid_i) begin
        r_skid <= data_i;
      end
    end
  end

  assign main_o = r_main;

endmodule

// File: rtl/pipe_skid_stage.sv
// Single pipeline stage with a 2-entry skid buffer. in_ready_o depends
// only on registered state, which breaks the ready path between stages.
// Optional feature macro: PIPE_SKID_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of cycles with out_valid_o=1 and out_ready_i=0.
// Ports:
//   clk_i, rst_i             clock / synchronous active-high reset
//   flush_i                  drop held and incoming data
//   in_valid_i/in_ready_o    upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i  downstream handshake, out_data_o payload
//   stall_cnt_o              back-pressure count (macro builds only)
module pipe_skid_stage
  import tinyriscv_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = SKID_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  // Elaboration-time parameter sanity checks.
  if ((WIDTH < 1) || (WIDTH > 256)) begin : g_bad_width
    $error("pipe_skid_stage: WIDTH must be 1..256");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_skid_stage: CNT_W must be >= 1");
  end

  skid_state_e r_state;
  skid_state_e w_next;
  logic        w_load_main;
  logic        w_load_skid;
  logic        w_main_from_skid;

  assign out_valid_o = (r_state != ST_EMPTY);
  assign in_ready_o  = (r_state != ST_SKID);

  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (in_valid_i) begin
          w_load_main = 1'b1;
          w_next      = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_valid_i && out_ready_i) begin
          // Main drains and refills in the same cycle.
          w_load_main = 1'b1;
        end else if (out_ready_i) begin
          w_next = ST_EMPTY;
        end else if (in_valid_i) begin
          // Downstream stalled while we were still ready: park the beat.
          w_load_skid = 1'b1;
          w_next      = ST_SKID;
        end
      end
      ST_SKID: begin
        if (out_ready_i) begin
          w_main_from_skid = 1'b1;
          w_next           = ST_FULL;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  pipe_skid_data #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_data (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (flush_i),
    .load_main_i      (w_load_main),
    .load_skid_i      (w_load_skid),
    .main_from_skid_i (w_main_from_skid),
    .data_i           (in_data_i),
    .main_o           (out_data_o)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int          W     = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] RV    = 32'h0BAD_F00D;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH     (W),
    .RESET_VAL (RV),
    .CNT_W     (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[15];

  // Reference model state: ordered list of accepted-but-not-delivered beats.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_data;
  int           m_cnt;

  initial begin
    // Table: inputs held for one edge, outputs expected just after it.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, RV};           // reset
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5}; // single beat
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA5A5A5A5}; // drained, data kept
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h11,       1'b0, 1'b1, 1'b1, 32'h11};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h22,       1'b0, 1'b1, 1'b0, 32'h11};       // SKID
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h99,       1'b0, 1'b1, 1'b0, 32'h11};       // ignored in SKID
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h22};       // 0x11 left
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h22};       // 0x22 left
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h44,       1'b0, 1'b1, 1'b1, 32'h44};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h55,       1'b0, 1'b1, 1'b0, 32'h44};       // SKID
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h33,       1'b0, 1'b0, 1'b1, RV};           // flush in SKID
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, RV};           // 0x33 never shows
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h66,       1'b0, 1'b1, 1'b1, 32'h66};       // FULL
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h77,       1'b1, 1'b0, 1'b1, RV};           // reset mid-stream
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, RV};

    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      step();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_data", i),  64'(out_data),  64'(tbl[i].e_d));
`ifdef PIPE_SKID_STALL_CNT_EN
      if (tbl[i].rst) check($sformatf("vec%0d_stall_cnt", i), 64'(stall_cnt), 64'd0);
`endif
    end

    // Streaming: 8 back-to-back beats with downstream always ready.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, W'(k), 1'b1);
      step();
      check($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d_data", k),  64'(out_data),  64'(k));
      check($sformatf("stream%0d_ready", k), 64'(in_ready),  64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    check("stream_end_valid", 64'(out_valid), 64'd0);

    // in_ready must not follow out_ready combinationally while in SKID.
    drive(1'b0, 1'b0, 1'b1, 32'hC1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'hC2, 1'b0);
    step();
    check("skid_in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    #1;
    check("skid_ready_no_comb", 64'(in_ready), 64'd0);
    step();
    check("skid_to_full_ready", 64'(in_ready), 64'd1);
    check("skid_to_full_data",  64'(out_data), 64'h C2);
    step();

`ifdef PIPE_SKID_STALL_CNT_EN
    // Counter saturation, then survival across flush.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    check("cnt_after_reset", 64'(stall_cnt), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hBEEF, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 19; k++) step();
    check("cnt_saturated", 64'(stall_cnt), 64'(CMAX));
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step();
    check("cnt_after_flush", 64'(stall_cnt), 64'(CMAX));
    check("cnt_flush_valid", 64'(out_valid), 64'd0);
`endif

    // Randomized run against a queue model of the buffer contents.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    mq.delete();
    m_data = RV;
    m_cnt  = 0;
    for (int c = 0; c < 400; c++) begin
      logic r, f, iv, ordy;
      logic [W-1:0] d;
      check("rnd_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("rnd_in_ready",  64'(in_ready),  64'(mq.size() < 2));
      check("rnd_out_data",  64'(out_data),  64'(m_data));
`ifdef PIPE_SKID_STALL_CNT_EN
      check("rnd_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
      r    = ($urandom_range(0, 99) < 2);
      f    = ($urandom_range(0, 99) < 4);
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 55);
      d    = $urandom;
      drive(r, f, iv, d, ordy);

      if (r) begin
        mq.delete();
        m_data = RV;
        m_cnt  = 0;
      end else begin
        if (mq.size() > 0 && !ordy && m_cnt < CMAX) m_cnt++;
        if (f) begin
          mq.delete();
          m_data = RV;
        end else begin
          logic acc;
          acc = iv && (mq.size() < 2);
          if (mq.size() > 0 && ordy) void'(mq.pop_front());
          if (acc) mq.push_back(d);
          if (mq.size() > 0) m_data = mq[0];
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
